// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: valid/ready requests become sequenced CE/OE/WE cycles.
// Optional feature macro SRAM_CTRL_BURST_EN adds req_len for multi-beat incrementing reads.
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int LEN_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_CTRL_BURST_EN
  input  logic [LEN_W-1:0]  req_len,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_t            state, state_nx;
  logic [3:0]        wait_cnt;
  logic              write_q, write_nx;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  beats_q, len_in;
  logic              dq_oe;
  logic              accept, more_beats;
  logic              ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx, rsp_valid_nx;

`ifdef SRAM_CTRL_BURST_EN
  assign len_in = req_len;
`else
  assign len_in = '0;
`endif

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;
  assign more_beats = (beats_q != '0);
  assign write_nx   = (state == IDLE) ? req_write : write_q;

  // The controller only drives the bus on writes; reads leave it to the SRAM.
  assign sram_dq = dq_oe ? wdata_q : {DATA_W{1'bz}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (wait_cnt == WAIT_LAST) state_nx = HOLD;
      HOLD:    state_nx = more_beats ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobe values for the cycle about to begin; registered below.
  always_comb begin
    ce_n_nx      = 1'b1;
    oe_n_nx      = 1'b1;
    we_n_nx      = 1'b1;
    dq_oe_nx     = 1'b0;
    rsp_valid_nx = 1'b0;
    case (state_nx)
      SETUP: begin
        ce_n_nx  = 1'b0;
        dq_oe_nx = write_nx;
        oe_n_nx  = write_nx;
      end
      ACCESS: begin
        ce_n_nx  = 1'b0;
        dq_oe_nx = write_nx;
        oe_n_nx  = write_nx;
        we_n_nx  = !write_nx;
      end
      HOLD: begin
        ce_n_nx      = 1'b0;
        dq_oe_nx     = write_nx;
        rsp_valid_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      dq_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      beats_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      sram_ce_n <= ce_n_nx;
      sram_oe_n <= oe_n_nx;
      sram_we_n <= we_n_nx;
      dq_oe     <= dq_oe_nx;
      rsp_valid <= rsp_valid_nx;
      wait_cnt  <= (state == ACCESS) ? wait_cnt + 4'd1 : 4'd0;

      if (accept) begin
        sram_addr <= req_addr;
        write_q   <= req_write;
        wdata_q   <= req_wdata;
        beats_q   <= req_write ? '0 : len_in;
      end else if (state == HOLD && more_beats) begin
        // Next burst beat; the address wraps naturally at 2^ADDR_W.
        sram_addr <= sram_addr + 1'b1;
        beats_q   <= beats_q - 1'b1;
      end

      if (state == ACCESS && state_nx == HOLD && !write_q)
        rsp_rdata <= sram_dq;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed and random requests against an SRAM model,
// with a reference memory feeding a scoreboard that a negedge monitor drains.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int WAIT   = 1;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SRAM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
`ifdef SRAM_CTRL_BURST_EN
  logic [LEN_W-1:0]  req_len = '0;
`endif
  logic              req_ready, rsp_valid, busy;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n, sram_oe_n, sram_we_n;
  wire  [DATA_W-1:0] sram_dq;

  sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef SRAM_CTRL_BURST_EN
    .req_len   (req_len),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- SRAM device model ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  bit model_en = 1'b0;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'((a * 37) ^ (a >> 5) ^ 8'h5A);
  endfunction

  // SRAM drives on read; when deselected the bus is parked at 0 so a stray
  // controller drive shows up as a nonzero value.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] :
                   (sram_ce_n ? {DATA_W{1'b0}} : {DATA_W{1'bz}});

  always @(posedge sram_we_n)
    if (model_en && !sram_ce_n) mem[sram_addr] = sram_dq;

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] last_rd = '0;

  function automatic logic [DATA_W-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    bit                write;
    int                addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                due;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Called just after a posedge. Holds req_valid, scrambling fields while the
  // controller is busy, and returns the cycle of the accept decision.
  task automatic issue(input bit wr, input int addr, input logic [DATA_W-1:0] wd,
                       input int len, input bit scramble, input bit expect_rsp,
                       output int acc);
    int n;
    int beats;
    exp_t e;
    n = 0;
    acc = -1;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      if (scramble) begin
        req_addr  = ADDR_W'($urandom);
        req_wdata = DATA_W'($urandom);
        req_write = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 1, 0);
      return;
    end
    req_write = wr;
    req_addr  = ADDR_W'(addr);
    req_wdata = wd;
`ifdef SRAM_CTRL_BURST_EN
    req_len   = LEN_W'(len);
`endif
    acc = cyc;
    beats = (wr || !BURST) ? 1 : len + 1;
    if (expect_rsp) begin
      for (int k = 0; k < beats; k++) begin
        e.write = wr;
        e.addr  = (addr + k) % DEPTH;
        e.wdata = wd;
        e.due   = acc + (WAIT + 3) * (k + 1);
        if (wr) begin
          ref_mem[e.addr] = wd;
          e.rdata = last_rd;
        end else begin
          e.rdata = ref_rd(e.addr);
          last_rd = e.rdata;
        end
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while ((sb.size() != 0 || busy) && n < 500) begin @(posedge clk); #1; n++; end
    check("drain_pending", sb.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // ---------------- monitor ----------------
  int   we_run = 0;
  int   oe_run = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_run = 0;
      oe_run = 0;
    end else if (model_en) begin
      check("we_oe_overlap", (!sram_we_n && !sram_oe_n), 0);
      if (!sram_oe_n) check("dq_contention_rd", sram_dq, ref_rd(int'(sram_addr)));
      if (sram_ce_n)  check("dq_idle_release", sram_dq, 0);

      if (!sram_we_n) begin
        we_run++;
        if (sb.size() != 0) check("dq_write_data", sram_dq, sb[0].wdata);
      end else if (we_run != 0) begin
        check("we_low_width", we_run, WAIT + 1);
        we_run = 0;
      end

      if (!sram_oe_n) oe_run++;
      else if (oe_run != 0) begin
        check("oe_low_width", oe_run, WAIT + 2);
        oe_run = 0;
      end

      if (rsp_valid) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("rsp_latency", cyc, mon_e.due);
          check("rsp_addr", sram_addr, mon_e.addr);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("hold_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b011);
          if (mon_e.write) check("dq_write_hold", sram_dq, mon_e.wdata);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2;
    int pool [8];
    for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, DEPTH - 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_dq", sram_dq, 0);
    rst_n = 1'b1;
    model_en = 1'b1;
    @(posedge clk); #1;

    // Write then read back.
    issue(1'b1, 'h00010, 8'hA5, 0, 1'b0, 1'b1, acc);
    idle(2);
    issue(1'b0, 'h00010, 8'h00, 0, 1'b0, 1'b1, acc);
    drain();

    // Read of the top address from preloaded contents.
    preload('h3FFFF, 8'h5C);
    issue(1'b0, 'h3FFFF, 8'h00, 0, 1'b0, 1'b1, acc);
    drain();

    // Request held while busy with changing fields: only the accepted ones count.
    issue(1'b1, 'h00123, 8'h3C, 0, 1'b1, 1'b1, acc);
    issue(1'b0, 'h00123, 8'h00, 0, 1'b1, 1'b1, acc2);
    check("b2b_accept_gap", acc2 - acc, WAIT + 4);
    issue(1'b0, 'h00010, 8'h00, 0, 1'b1, 1'b1, acc);
    check("b2b_accept_gap2", acc - acc2, WAIT + 4);
    drain();

    // Reset during read ACCESS aborts the access silently.
    issue(1'b0, 'h00010, 8'h00, 0, 1'b0, 1'b0, acc);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 1);
    check("abort_rdata", rsp_rdata, 0);
    check("abort_dq", sram_dq, 0);
    last_rd = '0;
    rst_n = 1'b1;
    idle(3);
    check("abort_no_pending", sb.size(), 0);

`ifdef SRAM_CTRL_BURST_EN
    // Wrapping burst across the top of the address space.
    preload('h3FFFE, 8'h11);
    preload('h3FFFF, 8'h22);
    preload('h00000, 8'h33);
    preload('h00001, 8'h44);
    issue(1'b0, 'h3FFFE, 8'h00, 3, 1'b0, 1'b1, acc);
    drain();
    check("burst_last_rdata", rsp_rdata, 8'h44);
`endif

    // Random traffic, mostly over a small address pool so reads hit writes.
    for (int i = 0; i < 40; i++) begin
      int a;
      bit wr;
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : pool[$urandom_range(0, 7)];
      wr = 1'($urandom_range(0, 1));
      issue(wr, a, DATA_W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, acc);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
